// File: rtl/mac_lanes_pkg.sv
// Shared mode codes, accumulate FSM encoding and result reduction for mac_lanes.
// MAC_SATURATE_EN selects clamping; the default build wraps.
package mac_lanes_pkg;

    localparam logic [1:0] MODE_MULT_ADD = 2'b00;
    localparam logic [1:0] MODE_ADD      = 2'b01;
    localparam logic [1:0] MODE_ACCUM    = 2'b10;
    localparam logic [1:0] MODE_MULT     = 2'b11;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } acc_state_e;

`ifdef MAC_SATURATE_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    // Caller truncates the result to w bits; without clamping that truncation is the wrap.
    function automatic logic signed [63:0] reduce(input logic signed [63:0] sum,
                                                  input int unsigned w,
                                                  output logic sat);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi     = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo     = -(64'sd1 <<< (w - 1));
        sat    = 1'b0;
        reduce = sum;
        if (SAT_EN && (sum > hi)) begin
            reduce = hi;
            sat    = 1'b1;
        end else if (SAT_EN && (sum < lo)) begin
            reduce = lo;
            sat    = 1'b1;
        end
    endfunction

endpackage

// File: rtl/mac_lane.sv
// One lane: S1 product/addend registers, S2 result, accumulator and sticky sat flag.
// Latency 2 cycles; S1 advances on s1_en_i, S2 on s2_en_i, both held by the parent on stall.
// Saturation behaviour follows MAC_SATURATE_EN via mac_lanes_pkg::reduce.
module mac_lane
    import mac_lanes_pkg::*;
#(
    parameter int WIDTH_A   = 8,
    parameter int WIDTH_B   = 8,
    parameter int OUT_WIDTH = WIDTH_A + WIDTH_B
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clear_i,
    input  logic                        s1_en_i,
    input  logic                        s2_en_i,
    input  logic [1:0]                  s2_mode_i,
    input  logic                        s2_last_i,
    input  logic signed [WIDTH_A-1:0]   a_i,
    input  logic signed [WIDTH_B-1:0]   b_i,
    input  logic signed [OUT_WIDTH-1:0] c_i,
    input  logic signed [OUT_WIDTH-1:0] d_i,
    output logic signed [OUT_WIDTH-1:0] data_o,
    output logic                        sat_o
);

    localparam int PW = WIDTH_A + WIDTH_B;
    localparam int SW = OUT_WIDTH + 1;

    logic signed [PW-1:0]        prod_q;
    logic signed [OUT_WIDTH-1:0] c_q, d_q, acc_q, data_q;
    logic                        acc_sat_q, sat_q;
    logic signed [SW-1:0]        p_ext, sum;
    logic signed [OUT_WIDTH-1:0] res;
    logic                        sat_now;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prod_q <= '0;
            c_q    <= '0;
            d_q    <= '0;
        end else if (clear_i) begin
            prod_q <= '0;
            c_q    <= '0;
            d_q    <= '0;
        end else if (s1_en_i) begin
            prod_q <= PW'(a_i) * PW'(b_i);
            c_q    <= c_i;
            d_q    <= d_i;
        end
    end

    always_comb begin
        sat_now = 1'b0;
        p_ext   = SW'(prod_q);
        case (s2_mode_i)
            MODE_MULT_ADD: sum = SW'(c_q) + p_ext;
            MODE_ADD:      sum = SW'(c_q) + SW'(d_q);
            MODE_ACCUM:    sum = SW'(acc_q) + p_ext;
            default:       sum = p_ext;
        endcase
        res = OUT_WIDTH'(reduce(64'(sum), OUT_WIDTH, sat_now));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q     <= '0;
            acc_sat_q <= 1'b0;
            data_q    <= '0;
            sat_q     <= 1'b0;
        end else if (clear_i) begin
            acc_q     <= '0;
            acc_sat_q <= 1'b0;
            data_q    <= '0;
            sat_q     <= 1'b0;
        end else if (s2_en_i) begin
            if (s2_mode_i == MODE_ACCUM) begin
                // Run closes: publish the total, then start the next run from zero.
                if (s2_last_i) begin
                    data_q    <= res;
                    sat_q     <= acc_sat_q | sat_now;
                    acc_q     <= '0;
                    acc_sat_q <= 1'b0;
                end else begin
                    acc_q     <= res;
                    acc_sat_q <= acc_sat_q | sat_now;
                end
            end else begin
                data_q <= res;
                sat_q  <= sat_now;
            end
        end
    end

    assign data_o = data_q;
    assign sat_o  = sat_q;

endmodule

// File: rtl/mac_lanes.sv
// Multi-lane multiply/add/accumulate with valid/ready handshake and run-length ACCUM.
// Latency 2 cycles, 1 beat/cycle; whole pipeline holds while out_valid && !out_ready.
// Optional clamping datapath enabled by MAC_SATURATE_EN.
module mac_lanes
    import mac_lanes_pkg::*;
#(
    parameter int LANES     = 2,
    parameter int WIDTH_A   = 8,
    parameter int WIDTH_B   = 8,
    parameter int OUT_WIDTH = WIDTH_A + WIDTH_B,
    parameter int LEN_WIDTH = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clear,
    input  logic [1:0]                   mode,
    input  logic [LEN_WIDTH-1:0]         acc_len,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [LANES*WIDTH_A-1:0]     data_in_a,
    input  logic [LANES*WIDTH_B-1:0]     data_in_b,
    input  logic [LANES*OUT_WIDTH-1:0]   add_data_in_a,
    input  logic [LANES*OUT_WIDTH-1:0]   add_data_in_b,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [LANES*OUT_WIDTH-1:0]   data_out,
    output logic                         out_last,
    output logic [LANES-1:0]             out_sat
);

    acc_state_e           state_q, state_d;
    logic [LEN_WIDTH-1:0] cnt_q, cnt_d;
    logic                 s1_vld_q, s1_last_q, out_valid_q, out_last_q;
    logic [1:0]           s1_mode_q, eff_mode;
    logic                 adv, accept, beat_last;

    assign adv      = !out_valid_q || out_ready;
    assign in_ready = adv && !clear && !rst;
    assign accept   = in_valid && in_ready;
    assign eff_mode = (state_q == ST_RUN) ? MODE_ACCUM : mode;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        beat_last = 1'b1;
        if (accept) begin
            case (state_q)
                ST_IDLE: begin
                    if (mode == MODE_ACCUM) begin
                        cnt_d = LEN_WIDTH'(1);
                        if (acc_len > LEN_WIDTH'(1)) begin
                            beat_last = 1'b0;
                            state_d   = ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    cnt_d = cnt_q + LEN_WIDTH'(1);
                    // >= rather than == so a shortened acc_len mid-run still terminates.
                    if (((LEN_WIDTH+1)'(cnt_q) + (LEN_WIDTH+1)'(1)) >= (LEN_WIDTH+1)'(acc_len))
                        state_d = ST_IDLE;
                    else
                        beat_last = 1'b0;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            s1_vld_q    <= 1'b0;
            s1_mode_q   <= MODE_MULT_ADD;
            s1_last_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else if (clear) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            s1_vld_q    <= 1'b0;
            s1_mode_q   <= MODE_MULT_ADD;
            s1_last_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (adv) begin
                s1_vld_q    <= accept;
                s1_mode_q   <= eff_mode;
                s1_last_q   <= beat_last;
                out_valid_q <= s1_vld_q && ((s1_mode_q != MODE_ACCUM) || s1_last_q);
                out_last_q  <= s1_last_q;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        mac_lane #(
            .WIDTH_A   (WIDTH_A),
            .WIDTH_B   (WIDTH_B),
            .OUT_WIDTH (OUT_WIDTH)
        ) u_lane (
            .clk       (clk),
            .rst       (rst),
            .clear_i   (clear),
            .s1_en_i   (adv),
            .s2_en_i   (adv && s1_vld_q),
            .s2_mode_i (s1_mode_q),
            .s2_last_i (s1_last_q),
            .a_i       (data_in_a[i*WIDTH_A +: WIDTH_A]),
            .b_i       (data_in_b[i*WIDTH_B +: WIDTH_B]),
            .c_i       (add_data_in_a[i*OUT_WIDTH +: OUT_WIDTH]),
            .d_i       (add_data_in_b[i*OUT_WIDTH +: OUT_WIDTH]),
            .data_o    (data_out[i*OUT_WIDTH +: OUT_WIDTH]),
            .sat_o     (out_sat[i])
        );
    end

endmodule
